// File: rtl/snake_step_ctrl_if.sv
// Handshake bundle between the snake step sequencer and its environment
// (direction logic, body FIFO, occupancy map, food randomizer).
interface snake_step_ctrl_if;
    logic       tick;
    logic       start;
    logic [1:0] dir_in;
    logic [7:0] occ_addr;
    logic       occ_q;
    logic       body_push;
    logic [7:0] body_data;
    logic       body_pop;
    logic [7:0] tail_pos;
    logic [7:0] food_pos;
    logic       food_valid;
    logic       food_req;
    logic [7:0] head_pos;
    logic [5:0] length;
    logic [7:0] score;
    logic [1:0] state;
    logic       dead;

    modport slave (
        input  tick, start, dir_in, occ_q, tail_pos, food_pos, food_valid,
        output occ_addr, body_push, body_data, body_pop, food_req,
               head_pos, length, score, state, dead
    );

    modport master (
        output tick, start, dir_in, occ_q, tail_pos, food_pos, food_valid,
        input  occ_addr, body_push, body_data, body_pop, food_req,
               head_pos, length, score, state, dead
    );
endinterface

// File: rtl/snake_step_ctrl.sv
// Snake game sequencer: one head step per tick (CALC/CHECK/COMMIT), body FIFO
// push/pop, growth, length/score keeping and IDLE/RUN/DEAD game state.
module snake_step_ctrl #(
    parameter int W        = 16,
    parameter int H        = 8,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 32,
    parameter int WRAP     = 1
) (
    input  logic             clk,
    input  logic             reset,
    snake_step_ctrl_if.slave bus
);
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;
    localparam logic [3:0] HALF_Y    = 4'(H / 2);
    localparam logic [3:0] INIT_X0   = 4'(2 - INIT_LEN + 1);

    typedef enum logic [2:0] {
        stIdle, stInit, stWait, stCalc, stCheck, stCommit, stDead
    } ctrlState_t;

    ctrlState_t stateReg, stateNext;
    logic [7:0] headReg, headNext, nxtReg, nxtNext, dataReg, dataNext;
    logic [1:0] dirReg, dirNext, dirEff;
    logic       wallReg, wallNext, growReg, growNext;
    logic [5:0] lenReg, lenNext;
    logic [7:0] scoreReg, scoreNext;
    logic       pushReg, pushNext, popReg, popNext, foodReqReg, foodReqNext;
    logic [3:0] stepX, stepY;
    logic       stepWall, grow, hit;

    // Opposite directions differ only in bit 0, so a reversal keeps the old heading.
    assign dirEff = (bus.dir_in == (dirReg ^ 2'b01)) ? dirReg : bus.dir_in;

    always_comb begin
        stepX    = headReg[7:4];
        stepY    = headReg[3:0];
        stepWall = 1'b0;
        unique case (dirEff)
            DIR_UP: begin
                if (headReg[3:0] == 4'd0) begin
                    stepY    = 4'(H - 1);
                    stepWall = (WRAP == 0);
                end else stepY = headReg[3:0] - 4'd1;
            end
            DIR_DOWN: begin
                if (headReg[3:0] == 4'(H - 1)) begin
                    stepY    = 4'd0;
                    stepWall = (WRAP == 0);
                end else stepY = headReg[3:0] + 4'd1;
            end
            DIR_LEFT: begin
                if (headReg[7:4] == 4'd0) begin
                    stepX    = 4'(W - 1);
                    stepWall = (WRAP == 0);
                end else stepX = headReg[7:4] - 4'd1;
            end
            DIR_RIGHT: begin
                if (headReg[7:4] == 4'(W - 1)) begin
                    stepX    = 4'd0;
                    stepWall = (WRAP == 0);
                end else stepX = headReg[7:4] + 4'd1;
            end
        endcase
    end

    // Entering the cell the tail leaves this same step is legal unless we grow.
    assign grow = bus.food_valid && (nxtReg == bus.food_pos);
    assign hit  = wallReg || (bus.occ_q && !((nxtReg == bus.tail_pos) && !grow));

    always_comb begin
        stateNext   = stateReg;
        headNext    = headReg;
        dirNext     = dirReg;
        nxtNext     = nxtReg;
        wallNext    = wallReg;
        growNext    = growReg;
        lenNext     = lenReg;
        scoreNext   = scoreReg;
        dataNext    = dataReg;
        pushNext    = 1'b0;
        popNext     = 1'b0;
        foodReqNext = 1'b0;
        unique case (stateReg)
            stIdle, stDead: begin
                if (bus.start) begin
                    stateNext   = stInit;
                    headNext    = {4'd2, HALF_Y};
                    dirNext     = DIR_RIGHT;
                    lenNext     = '0;
                    scoreNext   = '0;
                    wallNext    = 1'b0;
                    pushNext    = 1'b1;
                    dataNext    = {INIT_X0, HALF_Y};
                    foodReqNext = (INIT_LEN == 1);
                end
            end
            stInit: begin
                // length doubles as the index of the cell being pushed
                lenNext = lenReg + 6'd1;
                if (lenReg == 6'(INIT_LEN - 1)) begin
                    stateNext = stWait;
                end else begin
                    pushNext    = 1'b1;
                    dataNext    = {INIT_X0 + lenReg[3:0] + 4'd1, HALF_Y};
                    foodReqNext = (lenReg + 6'd1 == 6'(INIT_LEN - 1));
                end
            end
            stWait: begin
                if (bus.tick) begin
                    stateNext = stCalc;
                    dirNext   = dirEff;
                    nxtNext   = {stepX, stepY};
                    wallNext  = stepWall;
                end
            end
            stCalc: stateNext = stCheck;
            stCheck: begin
                if (hit) begin
                    stateNext = stDead;
                end else begin
                    stateNext   = stCommit;
                    pushNext    = 1'b1;
                    dataNext    = nxtReg;
                    growNext    = grow;
                    foodReqNext = grow;
                    popNext     = !grow || (lenReg == 6'(MAX_LEN));
                end
            end
            stCommit: begin
                stateNext = stWait;
                headNext  = nxtReg;
                if (growReg) begin
                    if (lenReg != 6'(MAX_LEN)) lenNext = lenReg + 6'd1;
                    if (scoreReg != 8'hFF) scoreNext = scoreReg + 8'd1;
                end
            end
            default: stateNext = stIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg   <= stIdle;
            headReg    <= '0;
            dirReg     <= DIR_RIGHT;
            nxtReg     <= '0;
            wallReg    <= 1'b0;
            growReg    <= 1'b0;
            lenReg     <= '0;
            scoreReg   <= '0;
            dataReg    <= '0;
            pushReg    <= 1'b0;
            popReg     <= 1'b0;
            foodReqReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            headReg    <= headNext;
            dirReg     <= dirNext;
            nxtReg     <= nxtNext;
            wallReg    <= wallNext;
            growReg    <= growNext;
            lenReg     <= lenNext;
            scoreReg   <= scoreNext;
            dataReg    <= dataNext;
            pushReg    <= pushNext;
            popReg     <= popNext;
            foodReqReg <= foodReqNext;
        end
    end

    assign bus.occ_addr  = nxtReg;
    assign bus.body_push = pushReg;
    assign bus.body_data = dataReg;
    assign bus.body_pop  = popReg;
    assign bus.food_req  = foodReqReg;
    assign bus.head_pos  = headReg;
    assign bus.length    = lenReg;
    assign bus.score     = scoreReg;
    assign bus.dead      = (stateReg == stDead);
    assign bus.state     = (stateReg == stIdle) ? 2'b00 :
                           (stateReg == stDead) ? 2'b10 : 2'b01;
endmodule

// File: tb/tb_snake_step_ctrl.sv
// Random and directed game play on a wrapping and a walled sequencer sharing one
// stimulus stream, checked every cycle against a cell-level snake model.
module tb_snake_step_ctrl;
    localparam int W = 16, H = 8, INIT_LEN = 3, MAX_LEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN, tick, start, occQ, foodValid;
    logic [1:0] dirIn;
    logic [7:0] tailPos, foodPos;

    snake_step_ctrl_if ifW();
    snake_step_ctrl_if ifN();

    assign ifW.tick = tick;       assign ifN.tick = tick;
    assign ifW.start = start;     assign ifN.start = start;
    assign ifW.dir_in = dirIn;    assign ifN.dir_in = dirIn;
    assign ifW.occ_q = occQ;      assign ifN.occ_q = occQ;
    assign ifW.tail_pos = tailPos;   assign ifN.tail_pos = tailPos;
    assign ifW.food_pos = foodPos;   assign ifN.food_pos = foodPos;
    assign ifW.food_valid = foodValid; assign ifN.food_valid = foodValid;

    snake_step_ctrl #(.W(W), .H(H), .INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN), .WRAP(1))
        dutW (.clk(clk), .reset(rstN), .bus(ifW.slave));
    snake_step_ctrl #(.W(W), .H(H), .INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN), .WRAP(0))
        dutN (.clk(clk), .reset(rstN), .bus(ifN.slave));

    // index 0 = wrapping instance, 1 = walled instance
    logic       obsPush [2], obsPop [2], obsFood [2], obsDead [2];
    logic [7:0] obsData [2], obsOcc [2], obsHead [2], obsScore [2];
    logic [5:0] obsLen [2];
    logic [1:0] obsState [2];
    assign obsPush[0] = ifW.body_push;  assign obsPush[1] = ifN.body_push;
    assign obsPop[0] = ifW.body_pop;    assign obsPop[1] = ifN.body_pop;
    assign obsFood[0] = ifW.food_req;   assign obsFood[1] = ifN.food_req;
    assign obsDead[0] = ifW.dead;       assign obsDead[1] = ifN.dead;
    assign obsData[0] = ifW.body_data;  assign obsData[1] = ifN.body_data;
    assign obsOcc[0] = ifW.occ_addr;    assign obsOcc[1] = ifN.occ_addr;
    assign obsHead[0] = ifW.head_pos;   assign obsHead[1] = ifN.head_pos;
    assign obsScore[0] = ifW.score;     assign obsScore[1] = ifN.score;
    assign obsLen[0] = ifW.length;      assign obsLen[1] = ifN.length;
    assign obsState[0] = ifW.state;     assign obsState[1] = ifN.state;

    int nVec = 0, nMis = 0;

    // Model: phase 0 idle, 1 running, 2 dead; body queue is the wrapping snake, tail first.
    logic [7:0] mHead [2];
    logic [1:0] mDir [2];
    int         mLen [2], mScore [2], mPhase [2];
    logic [7:0] body [$];
    logic [7:0] eNxt [2];
    bit         eWall [2], eHit [2], eGrow [2], ePop [2], running [2];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pack(input int x, input int y);
        return {x[3:0], y[3:0]};
    endfunction

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            2'd0: return 2'd1;
            2'd1: return 2'd0;
            2'd2: return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    function automatic bit inBody(input logic [7:0] p);
        foreach (body[k]) if (body[k] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic calcNext(input logic [7:0] h, input logic [1:0] cur, input logic [1:0] req,
                            input bit wrap, output logic [1:0] dOut, output logic [7:0] n,
                            output bit wall);
        int x, y;
        x = int'(h[7:4]);
        y = int'(h[3:0]);
        dOut = (req == opposite(cur)) ? cur : req;
        case (dOut)
            2'd0: y = y - 1;
            2'd1: y = y + 1;
            2'd2: x = x - 1;
            default: x = x + 1;
        endcase
        if (wrap) begin
            x = (x + W) % W;
            y = (y + H) % H;
            wall = 1'b0;
        end else wall = (x < 0) || (x >= W) || (y < 0) || (y >= H);
        n = pack(x, y);
    endtask

    task automatic checkCycle(input int i, input string ph, input bit ePush, input bit ePopV,
                              input bit eFood, input logic [7:0] eData);
        string p;
        p = $sformatf("%s[%0d]", ph, i);
        checkVal({p, ".push"}, obsPush[i], ePush);
        checkVal({p, ".pop"}, obsPop[i], ePopV);
        checkVal({p, ".food_req"}, obsFood[i], eFood);
        if (ePush) checkVal({p, ".body_data"}, obsData[i], eData);
        checkVal({p, ".head"}, obsHead[i], mHead[i]);
        checkVal({p, ".length"}, obsLen[i], mLen[i]);
        checkVal({p, ".score"}, obsScore[i], mScore[i]);
        checkVal({p, ".state"}, obsState[i], mPhase[i]);
        checkVal({p, ".dead"}, obsDead[i], mPhase[i] == 2);
    endtask

    task automatic resetModelAndCheck(input string ph);
        for (int i = 0; i < 2; i++) begin
            mHead[i] = 8'h00; mLen[i] = 0; mScore[i] = 0; mPhase[i] = 0;
            checkCycle(i, ph, 1'b0, 1'b0, 1'b0, 8'h00);
            checkVal($sformatf("%s[%0d].occ_addr", ph, i), obsOcc[i], 8'h00);
            checkVal($sformatf("%s[%0d].body_data", ph, i), obsData[i], 8'h00);
        end
        body.delete();
    endtask

    // Called right after a falling edge; both instances must be idle or dead.
    task automatic doStart();
        tick = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mPhase[i] = 1; mHead[i] = pack(2, H / 2); mDir[i] = 2'd3;
            mLen[i] = 0; mScore[i] = 0;
        end
        body.delete();
        for (int k = 0; k < INIT_LEN; k++) begin
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                checkCycle(i, "init", 1'b1, 1'b0, k == INIT_LEN - 1, pack(2 - INIT_LEN + 1 + k, H / 2));
                mLen[i]++;
            end
            body.push_back(pack(2 - INIT_LEN + 1 + k, H / 2));
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) checkCycle(i, "ready", 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // occMode: 0 from body, 1 free, 2 obstacle, 3 tail cell; foodMode: 0 none, 1 on nxt,
    // 2 on nxt but invalid, 3 random.
    task automatic doStep(input logic [1:0] d, input int occMode, input int foodMode,
                          input bit x1, input bit x2, input bit abort);
        logic [7:0] n0;
        logic [1:0] dd;
        bit w0;
        calcNext(mHead[0], mDir[0], d, 1'b1, dd, n0, w0);
        dirIn = d;
        tailPos = (body.size() > 0) ? body[0] : 8'h00;
        case (occMode)
            0: occQ = inBody(n0);
            1: occQ = 1'b0;
            2: begin occQ = 1'b1; if (tailPos == n0) tailPos = n0 ^ 8'h11; end
            default: begin occQ = 1'b1; tailPos = n0; end
        endcase
        case (foodMode)
            0: begin foodValid = 1'b0; foodPos = 8'($urandom); end
            1: begin foodValid = 1'b1; foodPos = n0; end
            2: begin foodValid = 1'b0; foodPos = n0; end
            default: begin foodValid = 1'($urandom); foodPos = 8'($urandom); end
        endcase
        for (int i = 0; i < 2; i++) begin
            running[i] = (mPhase[i] == 1);
            if (running[i]) begin
                calcNext(mHead[i], mDir[i], d, i == 0, dd, eNxt[i], eWall[i]);
                mDir[i] = dd;
                eGrow[i] = foodValid && (eNxt[i] == foodPos);
                eHit[i] = eWall[i] || (occQ && !((eNxt[i] == tailPos) && !eGrow[i]));
                ePop[i] = !eGrow[i] || (mLen[i] == MAX_LEN);
            end
        end
        tick = 1'b1;
        @(negedge clk);
        tick = x1;
        for (int i = 0; i < 2; i++) begin
            checkCycle(i, "calc", 1'b0, 1'b0, 1'b0, 8'h00);
            if (running[i] && !eWall[i]) checkVal($sformatf("calc[%0d].occ_addr", i), obsOcc[i], eNxt[i]);
        end
        @(negedge clk);
        tick = x2;
        for (int i = 0; i < 2; i++) begin
            checkCycle(i, "chk", 1'b0, 1'b0, 1'b0, 8'h00);
            if (running[i] && !eWall[i]) checkVal($sformatf("chk[%0d].occ_addr", i), obsOcc[i], eNxt[i]);
        end
        if (abort) begin
            rstN = 1'b0;
            #1;
            resetModelAndCheck("abort");
            @(negedge clk);
            tick = 1'b0;
            resetModelAndCheck("abort+1");
            rstN = 1'b1;
            return;
        end
        @(negedge clk);
        tick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (running[i] && eHit[i]) begin
                mPhase[i] = 2;
                checkCycle(i, "commit", 1'b0, 1'b0, 1'b0, 8'h00);
            end else if (running[i]) begin
                checkCycle(i, "commit", 1'b1, ePop[i], eGrow[i], eNxt[i]);
                mHead[i] = eNxt[i];
                if (eGrow[i] && mLen[i] < MAX_LEN) mLen[i]++;
                if (eGrow[i] && mScore[i] < 255) mScore[i]++;
                if (i == 0) begin
                    body.push_back(eNxt[i]);
                    if (ePop[i]) void'(body.pop_front());
                end
            end else checkCycle(i, "commit", 1'b0, 1'b0, 1'b0, 8'h00);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) checkCycle(i, "after", 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic randomStep();
        int r, occMode;
        r = $urandom_range(0, 99);
        occMode = (r < 4) ? 2 : (r < 10) ? 3 : 0;
        doStep(2'($urandom_range(0, 3)), occMode, $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic killGame();
        if (mPhase[0] == 1) doStep(mDir[0], 2, 0, 1'b0, 1'b0, 1'b0);
        randomStep();   // tick while dead must be ignored
    endtask

    initial begin
        int steps;
        rstN = 1'b0; tick = 1'b0; start = 1'b0; occQ = 1'b0; foodValid = 1'b0;
        dirIn = 2'd3; tailPos = 8'h00; foodPos = 8'h00;
        repeat (3) @(negedge clk);
        resetModelAndCheck("reset");
        rstN = 1'b1;
        @(negedge clk);

        // plain step, reversal with dropped ticks, growth, tail rule, tail+food death
        doStart();
        doStep(2'd3, 1, 0, 1'b0, 1'b0, 1'b0);
        doStep(2'd2, 1, 0, 1'b1, 1'b1, 1'b0);
        doStep(2'd3, 1, 1, 1'b0, 1'b0, 1'b0);
        doStep(2'd1, 3, 0, 1'b0, 1'b0, 1'b0);
        doStep(2'd3, 3, 1, 1'b0, 1'b0, 1'b0);
        killGame();

        // self-hit on a non-tail cell
        doStart();
        doStep(2'd0, 2, 0, 1'b0, 1'b0, 1'b0);
        killGame();

        // straight run right: wrap vs wall, growth up to and past MAX_LEN
        doStart();
        for (int s = 0; s < 40; s++) doStep(2'd3, 1, 1, 1'b0, 1'b0, 1'b0);
        killGame();

        for (int g = 0; g < 12; g++) begin
            doStart();
            steps = 0;
            while (mPhase[0] == 1 && steps < 30) begin
                randomStep();
                steps++;
            end
            killGame();
        end

        // reset in the middle of a step, then a clean restart
        doStart();
        doStep(2'd3, 1, 0, 1'b0, 1'b0, 1'b0);
        doStep(2'd3, 1, 1, 1'b0, 1'b0, 1'b1);
        doStart();
        doStep(2'd1, 1, 0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
